// File: rtl/rv_alu_arb_pkg.sv
// Shared RV32I R-type definitions and small helpers for the ALU
// arbitration block and its round-robin arbiter.
package rv_alu_arb_pkg;

  // Default datapath sizes.
  localparam int DEF_XLEN  = 32;
  localparam int DEF_TAG_W = 5;

  // RV32I R-type funct3 encodings.
  localparam logic [2:0] F3_ADD  = 3'b000;  // ADD / SUB
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;  // SRL / SRA
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7[5] set selects the alternate op (SUB, SRA).
  localparam logic FUNCT7_R_ALT = 1'b1;

  // Increment an index with wrap at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// rr_ptr (wrapping), only while enabled. rr_ptr moves past the granted
// requester only when the grant is actually taken (advance).
module rv_rr_arbiter
  import rv_alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             en,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic             found;
  int               cand;

  // Priority search starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      sel = IDX_W'(cand);
      if (en && !found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves one past the winner on each accepted grant only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= IDX_W'(wrap_inc(int'(grant_idx), NREQ));
    end
  end

endmodule

// File: rtl/rv_alu_arb.sv
// Shares one external combinational RV32I R-type ALU between NREQ
// requesters. The granted requester's operands drive the ALU; the result
// is captured with its tag in a single-entry slot and returned on a
// one-hot response handshake one cycle after accept.
module rv_alu_arb
  import rv_alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*XLEN-1:0]  req_rs1,
  input  logic [NREQ*XLEN-1:0]  req_rs2,
  input  logic [NREQ*3-1:0]     req_funct3,
  input  logic [NREQ-1:0]       req_funct7_r,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [XLEN-1:0]       alu_rs1,
  output logic [XLEN-1:0]       alu_rs2,
  output logic [2:0]            alu_funct3,
  output logic                  alu_funct7_r,
  input  logic [XLEN-1:0]       alu_rd,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic [TAG_W-1:0]      rsp_tag
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             slot_free;
  logic             accept;
  logic [TAG_W-1:0] tag_sel;

  logic [NREQ-1:0]  rsp_valid_p1;
  logic [XLEN-1:0]  rsp_data_p1;
  logic [TAG_W-1:0] rsp_tag_p1;
  logic [IDX_W-1:0] owner_p1;

  // The slot can take a new op when empty or being drained this cycle;
  // this is a deliberate combinational path from rsp_ready to req_ready.
  assign slot_free = ~(|rsp_valid_p1) | rsp_ready[owner_p1];

  rv_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (slot_free),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is already qualified by valid and slot_free.
  assign req_ready = grant;
  assign accept    = |grant;

  // Operand mux: granted requester's fields, all zero when idle.
  always_comb begin
    alu_rs1      = '0;
    alu_rs2      = '0;
    alu_funct3   = '0;
    alu_funct7_r = 1'b0;
    tag_sel      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_rs1      = req_rs1[i*XLEN +: XLEN];
        alu_rs2      = req_rs2[i*XLEN +: XLEN];
        alu_funct3   = req_funct3[i*3 +: 3];
        alu_funct7_r = req_funct7_r[i];
        tag_sel      = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // ---- p0 -> p1: result slot capture / drain ----
  // Capture on accept; clear valid on drain; data and tag hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_p1 <= '0;
      rsp_data_p1  <= '0;
      rsp_tag_p1   <= '0;
      owner_p1     <= '0;
    end else if (accept) begin
      rsp_valid_p1 <= grant;
      rsp_data_p1  <= alu_rd;
      rsp_tag_p1   <= tag_sel;
      owner_p1     <= grant_idx;
    end else if (slot_free) begin
      rsp_valid_p1 <= '0;
    end
  end

  assign rsp_valid = rsp_valid_p1;
  assign rsp_data  = rsp_data_p1;
  assign rsp_tag   = rsp_tag_p1;

endmodule

// File: tb/tb_rv_alu_arb.sv
// Directed, table-driven bench for rv_alu_arb with a behavioural model of
// the external RV32I R-type ALU.
module tb_rv_alu_arb;
  import rv_alu_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*XLEN-1:0]  req_rs1;
  logic [NREQ*XLEN-1:0]  req_rs2;
  logic [NREQ*3-1:0]     req_funct3;
  logic [NREQ-1:0]       req_funct7_r;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [XLEN-1:0]       alu_rs1;
  logic [XLEN-1:0]       alu_rs2;
  logic [2:0]            alu_funct3;
  logic                  alu_funct7_r;
  logic [XLEN-1:0]       alu_rd;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [XLEN-1:0]       rsp_data;
  logic [TAG_W-1:0]      rsp_tag;

  rv_alu_arb #(
    .NREQ  (NREQ),
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_funct3   (req_funct3),
    .req_funct7_r (req_funct7_r),
    .req_tag      (req_tag),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_funct3   (alu_funct3),
    .alu_funct7_r (alu_funct7_r),
    .alu_rd       (alu_rd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: legal R-type ops, zero for illegal funct combos.
  always_comb begin
    alu_rd = '0;
    case (alu_funct3)
      F3_ADD:  alu_rd = alu_funct7_r ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
      F3_SLL:  if (!alu_funct7_r) alu_rd = alu_rs1 << alu_rs2[4:0];
      F3_SLT:  if (!alu_funct7_r) alu_rd = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
      F3_SLTU: if (!alu_funct7_r) alu_rd = {31'b0, alu_rs1 < alu_rs2};
      F3_XOR:  if (!alu_funct7_r) alu_rd = alu_rs1 ^ alu_rs2;
      F3_SR:   alu_rd = alu_funct7_r ? 32'($signed(alu_rs1) >>> alu_rs2[4:0])
                                     : alu_rs1 >> alu_rs2[4:0];
      F3_OR:   if (!alu_funct7_r) alu_rd = alu_rs1 | alu_rs2;
      F3_AND:  if (!alu_funct7_r) alu_rd = alu_rs1 & alu_rs2;
      default: alu_rd = '0;
    endcase
  end

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  tag;
  } op_t;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rrdy;
    op_t         op0;
    op_t         op1;
    logic [1:0]  e_ready;
    logic [1:0]  e_vld;
    logic [31:0] e_data;
    logic [4:0]  e_tag;
  } vec_t;

  int tests;
  int fails;
  vec_t vq[$];
  vec_t v;
  op_t  nop, add57, sub, sra, add12, ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t a);
    req_valid    = a.valid;
    rsp_ready    = a.rrdy;
    req_rs1      = {a.op1.rs1, a.op0.rs1};
    req_rs2      = {a.op1.rs2, a.op0.rs2};
    req_funct3   = {a.op1.f3, a.op0.f3};
    req_funct7_r = {a.op1.f7, a.op0.f7};
    req_tag      = {a.op1.tag, a.op0.tag};
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nop   = '{32'd0, 32'd0, F3_ADD, 1'b0, 5'd0};
    add57 = '{32'd5, 32'd7, F3_ADD, 1'b0, 5'd3};
    sub   = '{32'd10, 32'd3, F3_ADD, FUNCT7_R_ALT, 5'd1};
    sra   = '{32'h8000_0000, 32'd4, F3_SR, FUNCT7_R_ALT, 5'd2};
    add12 = '{32'd1, 32'd2, F3_ADD, 1'b0, 5'd4};
    ill   = '{32'd5, 32'd7, F3_AND, FUNCT7_R_ALT, 5'd9};

    // Contention from reset: grants alternate 0,1,0,1 with no bubbles.
    vq.push_back('{2'b11, 2'b11, sub, sra, 2'b01, 2'b01, 32'd7, 5'd1});
    vq.push_back('{2'b11, 2'b11, sub, sra, 2'b10, 2'b10, 32'hF800_0000, 5'd2});
    vq.push_back('{2'b11, 2'b11, sub, sra, 2'b01, 2'b01, 32'd7, 5'd1});
    vq.push_back('{2'b11, 2'b11, sub, sra, 2'b10, 2'b10, 32'hF800_0000, 5'd2});
    // Backpressure on req1's result; non-owner rsp_ready ignored; refill on drain.
    vq.push_back('{2'b01, 2'b00, add57, nop, 2'b00, 2'b10, 32'hF800_0000, 5'd2});
    vq.push_back('{2'b01, 2'b00, add57, nop, 2'b00, 2'b10, 32'hF800_0000, 5'd2});
    vq.push_back('{2'b01, 2'b01, add57, nop, 2'b00, 2'b10, 32'hF800_0000, 5'd2});
    vq.push_back('{2'b01, 2'b10, add57, nop, 2'b01, 2'b01, 32'd12, 5'd3});
    // Drain with no new op: valid drops, data/tag retained.
    vq.push_back('{2'b00, 2'b11, nop, nop, 2'b00, 2'b00, 32'd12, 5'd3});
    // Single request with rr_ptr at 1 wraps to req0.
    vq.push_back('{2'b01, 2'b11, add57, nop, 2'b01, 2'b01, 32'd12, 5'd3});
    // Fairness: req1 alone twice, then contention goes to req0 (illegal op -> 0).
    vq.push_back('{2'b10, 2'b11, nop, add12, 2'b10, 2'b10, 32'd3, 5'd4});
    vq.push_back('{2'b10, 2'b11, nop, add12, 2'b10, 2'b10, 32'd3, 5'd4});
    vq.push_back('{2'b11, 2'b11, ill, add12, 2'b01, 2'b01, 32'd0, 5'd9});
    vq.push_back('{2'b11, 2'b11, ill, add12, 2'b10, 2'b10, 32'd3, 5'd4});
    // Idle keeps rr_ptr at 0, so the next contention still picks req0.
    vq.push_back('{2'b00, 2'b11, nop, nop, 2'b00, 2'b00, 32'd3, 5'd4});
    vq.push_back('{2'b11, 2'b11, add57, add12, 2'b01, 2'b01, 32'd12, 5'd3});

    rst_n = 1'b0;
    apply('{2'b00, 2'b00, nop, nop, 2'b00, 2'b00, 32'd0, 5'd0});
    #2;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data",  rsp_data, 32'd0);
    chk("reset rsp_tag",   32'(rsp_tag), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      apply(v);
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(v.e_vld));
      chk($sformatf("v%0d rsp_data", i),  rsp_data, v.e_data);
      chk($sformatf("v%0d rsp_tag", i),   32'(rsp_tag), 32'(v.e_tag));
    end

    // Asynchronous reset while a req0 result is pending.
    @(negedge clk);
    apply('{2'b00, 2'b00, nop, nop, 2'b00, 2'b00, 32'd0, 5'd0});
    #2;
    chk("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async rst rsp_data",  rsp_data, 32'd0);
    chk("async rst alu_rs1",   alu_rs1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply('{2'b11, 2'b11, add57, add12, 2'b00, 2'b00, 32'd0, 5'd0});
    #1;
    chk("post-rst req_ready", 32'(req_ready), 32'd1);
    chk("post-rst alu_rs1",   alu_rs1, 32'd5);
    @(posedge clk);
    #1;
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post-rst rsp_data",  rsp_data, 32'd12);
    chk("post-rst rsp_tag",   32'(rsp_tag), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_alu_arb.md
Name: rv_alu_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational RV32I R-type ALU between NREQ requesters, e.g. the integer pipe and a secondary issue port.
- Accepts operations on per-requester valid/ready channels and drives the shared ALU operand/function inputs from the granted requester.
- Captures the ALU result in a single-entry output register and returns it with the requester's tag on a one-hot response handshake.
- Sits in EX between the issue logic and the ALU; the ALU itself stays outside this block.

Parameters:
- NREQ, 2, number of requesters (2..4).
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the opaque tag (normally the rd index) carried with each operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_rs1  in  NREQ*XLEN  rs1 operands, requester i at [i*XLEN +: XLEN].
- req_rs2  in  NREQ*XLEN  rs2 operands, same packing.
- req_funct3  in  NREQ*3  funct3 per requester.
- req_funct7_r  in  NREQ  funct7[5] per requester.
- req_tag  in  NREQ*TAG_W  tag per requester.
- alu_rs1  out  XLEN  shared ALU rs1.
- alu_rs2  out  XLEN  shared ALU rs2.
- alu_funct3  out  3  shared ALU funct3.
- alu_funct7_r  out  1  shared ALU funct7[5].
- alu_rd  in  XLEN  shared ALU combinational result.
- rsp_valid  out  NREQ  one-hot: result pending for requester i.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_data  out  XLEN  registered result.
- rsp_tag  out  TAG_W  tag of the registered result.

Behaviour:
- Reset (async, rst_n low): rsp_valid=0, rsp_data=0, rsp_tag=0, owner=0, rr_ptr=0. req_ready=0 and alu_* =0 follow combinationally while rsp slot state is reset.
- Slot free condition: slot_free = !any(rsp_valid) | rsp_ready[owner]. Draining and refilling in the same cycle is legal. This creates a combinational path from rsp_ready to req_ready, by design.
- Grant (combinational):
  - If slot_free, grant goes to the first i with req_valid[i] set, searching from rr_ptr upward with wrap at NREQ.
  - req_ready = onehot(grant) & slot_free.
  - No grant when slot not free or no valid.
- ALU drive:
  - alu_rs1/rs2/funct3/funct7_r = granted requester's fields.
  - All zero when no grant, to avoid toggling.
- Accept (req_valid[g] & req_ready[g]) at edge N:
  - rsp_data <= alu_rd; rsp_tag <= req_tag[g]; owner <= g; rsp_valid <= onehot(g).
  - rr_ptr <= (g+1) mod NREQ.
- Latency: result visible the cycle after accept, i.e. fixed 1 cycle. Throughput is 1 op/cycle when responses are consumed immediately.
- Response:
  - rsp_valid[owner], rsp_data and rsp_tag are held stable until rsp_ready[owner].
  - rsp_ready for non-owner bits is ignored.
  - On drain with no new accept, rsp_valid <= 0; rsp_data and rsp_tag retain their last values.
- rr_ptr changes only on accept. Idle cycles and stalls keep it unchanged.
- Requesters may change fields while not accepted; the arbiter does not require stability. A requester's grant can move to another requester before acceptance, since rr priority is re-evaluated every cycle.
- Illegal funct codes are passed through unchanged; the ALU returns 0 and the result is delivered normally.
- Reset mid-operation: any pending result is discarded with no response, and arbitration restarts at requester 0.
- Arithmetic: no width conversion; XLEN bits in and out.

Decomposition:
- Shared package/include with the existing RV definitions:
  - RV32 funct3 constants (ADD=000 … AND=111).
  - FUNCT7_R_ALT=1 (SUB/SRA).
  - Default XLEN/TAG_W.
- One natural sub-module: rv_rr_arbiter.
  - Parameter NREQ.
  - Inputs: req vector, enable (slot_free), advance.
  - Outputs: one-hot grant; holds rr_ptr.
- Operand mux, result register and response logic stay in rv_alu_arb.

Test Plan:
- Single request: req0 ADD rs1=5 rs2=7 tag=3, rsp_ready=1 → req_ready[0]=1 in that cycle; next cycle rsp_valid=01, rsp_data=12, rsp_tag=3.
- Contention: both requesters valid every cycle, req0 SUB 10-3, req1 SRA 0x80000000>>4 → grants alternate 0,1,0,1 starting at 0; responses 7 then 0xF8000000, back-to-back with no bubbles.
- Backpressure: result pending for req1 with rsp_ready=0 for 3 cycles while req0 is valid → req_ready=0 throughout; rsp_data/rsp_tag/rsp_valid=10 stable; req0 is accepted in the same cycle rsp_ready[1] rises.
- Fairness with idle: req1 only valid for 2 ops, then both valid → first contended grant goes to req0 (rr_ptr=0 after req1 accept).
- Illegal op: req0 funct7_r=1, funct3=111 → rsp_data=0, response still delivered with the correct tag.
- Reset mid-op: assert rst_n=0 asynchronously while rsp_valid=01 → rsp_valid=0 immediately; after release, first grant goes to req0.
